// File: rtl/aes_pkg.sv
// aes_pkg: types and helpers shared by the ShiftRows datapath.
//   sr_mode_e   : row-shift direction (SR_FWD = encrypt, SR_INV = decrypt)
//   nb_is_legal : true for the supported block widths (4, 6 or 8 columns)
//   sr_offset   : left-rotation amount of a state row for a given width
package aes_pkg;

  typedef enum logic {
    SR_FWD = 1'b0,
    SR_INV = 1'b1
  } sr_mode_e;

  function automatic bit nb_is_legal(input int nb);
    return (nb == 32'sd4) || (nb == 32'sd6) || (nb == 32'sd8);
  endfunction

  // Rijndael row shifts: rows 2/3 move further only for the 256-bit block.
  function automatic int sr_offset(input int nb, input int row);
    int off;
    case (row)
      32'sd0:  off = 32'sd0;
      32'sd1:  off = 32'sd1;
      32'sd2:  off = (nb == 32'sd8) ? 32'sd3 : 32'sd2;
      32'sd3:  off = (nb == 32'sd8) ? 32'sd4 : 32'sd3;
      default: off = 32'sd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows / InvShiftRows byte permutation.
//   NB       : number of state columns (4, 6 or 8)
//   mode     : SR_FWD rotates row r left by its offset, SR_INV rotates right
//   state    : input state, byte k = 4*col + row at bits [8k +: 8]
//   permuted : permuted state, same byte layout
// Every byte routing is fixed at elaboration, so the logic is a 2:1 mux per byte.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  sr_mode_e          mode,
  input  logic [0:32*NB-1]  state,
  output logic [0:32*NB-1]  permuted
);

  for (genvar col = 0; col < NB; col++) begin : g_col
    for (genvar row = 0; row < 4; row++) begin : g_row
      localparam int SHIFT   = sr_offset(NB, row);
      localparam int FWD_COL = (col + SHIFT) % NB;
      // Adding NB keeps the operand non-negative before the modulo.
      localparam int INV_COL = (col - SHIFT + NB) % NB;
      localparam int DST     = 8 * (4 * col + row);
      localparam int SRC_FWD = 8 * (4 * FWD_COL + row);
      localparam int SRC_INV = 8 * (4 * INV_COL + row);

      assign permuted[DST +: 8] = (mode == SR_INV) ? state[SRC_INV +: 8]
                                                   : state[SRC_FWD +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered, valid/ready handshaked ShiftRows/InvShiftRows
// stage with per-block direction select and a side-band tag.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   clr               : synchronous flush of every held block
//   in_valid/in_ready : input handshake; in_mode, in_tag, in_state travel together
//   out_valid/out_ready : output handshake; out_mode, out_tag, out_state are flops
// The permutation is applied on the input side, so the output register holds
// the finished result.
// Build option SHIFT_ROWS_SKID_EN: adds a skid register behind the output
// register so in_ready becomes a flop with no out_ready -> in_ready path.
// Without it a single output register is used and in_ready is combinational.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [0:32*NB-1]   in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [TAG_W-1:0]   out_tag,
  output logic [0:32*NB-1]   out_state
);

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  sr_mode_e          in_mode_s;
  logic [0:32*NB-1]  perm_s;
  logic              accept_s;
  logic              pop_s;

  assign in_mode_s = sr_mode_e'(in_mode);

  shift_rows_perm #(.NB(NB)) u_perm (
    .mode     (in_mode_s),
    .state    (in_state),
    .permuted (perm_s)
  );

  assign accept_s = in_valid && in_ready;
  assign pop_s    = out_valid && out_ready;

`ifdef SHIFT_ROWS_SKID_EN

  logic              ready_r;
  logic              skid_valid_r;
  logic              skid_mode_r;
  logic [TAG_W-1:0]  skid_tag_r;
  logic [0:32*NB-1]  skid_state_r;

  logic              load_main_in_s;
  logic              load_main_skid_s;
  logic              clear_main_s;
  logic              load_skid_s;
  logic              skid_valid_next_s;

  assign in_ready = ready_r && !clr;

  // Decide where the incoming block goes and how the two entries move.
  always_comb begin
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    clear_main_s     = 1'b0;
    load_skid_s      = 1'b0;
    if (!out_valid) begin
      load_main_in_s = accept_s;
    end else if (skid_valid_r) begin
      // Skid full means in_ready is low, so only a drain can happen.
      load_main_skid_s = pop_s;
    end else if (pop_s) begin
      load_main_in_s = accept_s;
      clear_main_s   = !accept_s;
    end else begin
      load_skid_s = accept_s;
    end
  end

  // Skid occupancy after this edge; it also sets next-cycle in_ready.
  always_comb begin
    skid_valid_next_s = skid_valid_r;
    if (clr) begin
      skid_valid_next_s = 1'b0;
    end else if (load_skid_s) begin
      skid_valid_next_s = 1'b1;
    end else if (load_main_skid_s) begin
      skid_valid_next_s = 1'b0;
    end else begin
      skid_valid_next_s = skid_valid_r;
    end
  end

  // Main output register: loaded from input or drained from the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      out_state <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (load_main_in_s) begin
      out_valid <= 1'b1;
      out_mode  <= in_mode;
      out_tag   <= in_tag;
      out_state <= perm_s;
    end else if (load_main_skid_s) begin
      out_valid <= 1'b1;
      out_mode  <= skid_mode_r;
      out_tag   <= skid_tag_r;
      out_state <= skid_state_r;
    end else if (clear_main_s) begin
      out_valid <= 1'b0;
    end
  end

  // Skid register and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r      <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_mode_r  <= 1'b0;
      skid_tag_r   <= '0;
      skid_state_r <= '0;
    end else begin
      ready_r      <= !skid_valid_next_s;
      skid_valid_r <= skid_valid_next_s;
      if (load_skid_s && !clr) begin
        skid_mode_r  <= in_mode;
        skid_tag_r   <= in_tag;
        skid_state_r <= perm_s;
      end
    end
  end

`else

  logic ready_en_r;

  // Keeps in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  assign in_ready = ready_en_r && !clr && (!out_valid || out_ready);

  // Single output register; accept on a pop replaces the block without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      out_state <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_mode  <= in_mode;
      out_tag   <= in_tag;
      out_state <= perm_s;
    end else if (pop_s) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 and NB=8 instances sharing clock,
// reset and clr. Expected states are hand-derived constants.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n, clr;

  logic v4, r4, m4, ov4, ordy4, om4;
  logic [3:0] t4, ot4;
  logic [0:127] s4, os4;

  logic v8, r8, m8, ov8, ordy8, om8;
  logic [3:0] t8, ot8;
  logic [0:255] s8, os8;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [0:127] A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] FA = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [0:127] IA = 128'h000d0a0704010e0b0805020f0c090603;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(v4), .in_ready(r4), .in_mode(m4), .in_tag(t4), .in_state(s4),
    .out_valid(ov4), .out_ready(ordy4), .out_mode(om4), .out_tag(ot4), .out_state(os4)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(v8), .in_ready(r8), .in_mode(m8), .in_tag(t8), .in_state(s8),
    .out_valid(ov8), .out_ready(ordy8), .out_mode(om8), .out_tag(ot8), .out_state(os8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [0:127] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one block on the NB=4 port, wait (bounded) for in_ready, transfer.
  task automatic send4(input logic mode, input logic [3:0] tag, input logic [0:127] st);
    v4 = 1'b1; m4 = mode; t4 = tag; s4 = st;
    #1;
    for (int n = 0; n < 20 && !r4; n++) step();
    chk("send4_ready", 256'(r4), 256'(1'b1));
    step();
    v4 = 1'b0;
  endtask

  initial begin
    logic [0:255] rnd, fw;
    logic [7:0] x;

    rst_n = 1'b0; clr = 1'b0;
    v4 = 1'b0; m4 = 1'b0; t4 = 4'h0; s4 = '0; ordy4 = 1'b1;
    v8 = 1'b0; m8 = 1'b0; t8 = 4'h0; s8 = '0; ordy8 = 1'b1;
    #12;
    chk("rst_out_valid", 256'(ov4), 256'(1'b0));
    chk("rst_out_state", 256'(os4), 256'(0));
    chk("rst_out_tag",   256'(ot4), 256'(0));
    chk("rst_out_mode",  256'(om4), 256'(1'b0));
    chk("rst_in_ready",  256'(r4),  256'(1'b0));
    chk("rst_out_state8", 256'(os8), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 256'(r4), 256'(1'b0));
    step();
    chk("ready_after_release", 256'(r4), 256'(1'b1));
    chk("ready8_after_release", 256'(r8), 256'(1'b1));

    // NB=4 forward, inverse and round trip.
    send4(1'b0, 4'h3, A);
    chk("fwd_valid", 256'(ov4), 256'(1'b1));
    chk("fwd_state", 256'(os4), 256'(FA));
    chk("fwd_mode",  256'(om4), 256'(1'b0));
    chk("fwd_tag",   256'(ot4), 256'(4'h3));
    step();
    chk("fwd_drained", 256'(ov4), 256'(1'b0));
    send4(1'b1, 4'h9, A);
    chk("inv_state", 256'(os4), 256'(IA));
    chk("inv_mode",  256'(om4), 256'(1'b1));
    chk("inv_tag",   256'(ot4), 256'(4'h9));
    send4(1'b1, 4'h4, FA);
    chk("roundtrip4", 256'(os4), 256'(A));
    step();

    // Back-to-back: 8 blocks, alternating mode, tags 0..7. XOR with a
    // replicated byte commutes with the permutation.
    for (int i = 0; i < 8; i++) begin
      x = 8'(i * 17);
      v4 = 1'b1; m4 = i[0]; t4 = 4'(i); s4 = A ^ rep(x);
      #1;
      chk("b2b_ready", 256'(r4), 256'(1'b1));
      step();
      chk("b2b_valid", 256'(ov4), 256'(1'b1));
      chk("b2b_tag",   256'(ot4), 256'(4'(i)));
      chk("b2b_mode",  256'(om4), 256'(i[0]));
      chk("b2b_state", 256'(os4), 256'((i[0] ? IA : FA) ^ rep(x)));
    end
    v4 = 1'b0;
    step();
    chk("b2b_drained", 256'(ov4), 256'(1'b0));

    // Backpressure for 5 cycles.
    ordy4 = 1'b0;
    send4(1'b0, 4'h1, A);
    chk("bp_first", 256'(ot4), 256'(4'h1));
    v4 = 1'b1; m4 = 1'b1; t4 = 4'h2; s4 = A;
    #1;
`ifdef SHIFT_ROWS_SKID_EN
    chk("bp_skid_ready", 256'(r4), 256'(1'b1));
    step();
    chk("bp_skid_held_tag", 256'(ot4), 256'(4'h1));
    chk("bp_skid_full_ready", 256'(r4), 256'(1'b0));
    m4 = 1'b0; t4 = 4'h3; s4 = A ^ rep(8'h33);
`endif
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 256'(r4), 256'(1'b0));
      step();
      chk("bp_hold_valid", 256'(ov4), 256'(1'b1));
      chk("bp_hold_tag",   256'(ot4), 256'(4'h1));
      chk("bp_hold_state", 256'(os4), 256'(FA));
    end
    ordy4 = 1'b1;
    #1;
`ifdef SHIFT_ROWS_SKID_EN
    step();
    chk("bp_drain_tag",   256'(ot4), 256'(4'h2));
    chk("bp_drain_state", 256'(os4), 256'(IA));
    chk("bp_drain_ready", 256'(r4),  256'(1'b1));
    step();
    chk("bp_third_tag",   256'(ot4), 256'(4'h3));
    chk("bp_third_state", 256'(os4), 256'(FA ^ rep(8'h33)));
`else
    chk("bp_release_ready", 256'(r4), 256'(1'b1));
    step();
    chk("bp_second_tag",   256'(ot4), 256'(4'h2));
    chk("bp_second_state", 256'(os4), 256'(IA));
`endif
    v4 = 1'b0;
    step();
    chk("bp_drained", 256'(ov4), 256'(1'b0));

    // clr with the stage full and a block offered: everything is dropped.
    ordy4 = 1'b0;
    send4(1'b0, 4'h5, A);
`ifdef SHIFT_ROWS_SKID_EN
    send4(1'b1, 4'h6, A);
`endif
    v4 = 1'b1; m4 = 1'b0; t4 = 4'h7; s4 = A; clr = 1'b1;
    #1;
    chk("clr_ready_low", 256'(r4), 256'(1'b0));
    step();
    clr = 1'b0; v4 = 1'b0;
    chk("clr_valid", 256'(ov4), 256'(1'b0));
    #1;
    chk("clr_ready_back", 256'(r4), 256'(1'b1));
    step();
    chk("clr_input_dropped", 256'(ov4), 256'(1'b0));
    ordy4 = 1'b1;

    // Asynchronous reset mid-stream.
    send4(1'b1, 4'hc, A);
    chk("pre_rst_valid", 256'(ov4), 256'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 256'(ov4), 256'(1'b0));
    chk("arst_state", 256'(os4), 256'(0));
    chk("arst_tag",   256'(ot4), 256'(0));
    chk("arst_mode",  256'(om4), 256'(1'b0));
    chk("arst_ready", 256'(r4),  256'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 256'(r4), 256'(1'b1));
    send4(1'b0, 4'h2, A);
    chk("post_rst_state", 256'(os4), 256'(FA));
    step();

    // NB=8: byte k = k.
    for (int k = 0; k < 32; k++) s8[8*k +: 8] = 8'(k);
    v8 = 1'b1; m8 = 1'b0; t8 = 4'ha;
    step();
    v8 = 1'b0;
    chk("nb8_fwd_valid", 256'(ov8), 256'(1'b1));
    chk("nb8_fwd_col0",  256'(os8[0:31]),    256'(32'h00050e13));
    chk("nb8_fwd_col7",  256'(os8[224:255]), 256'(32'h1c010a0f));
    chk("nb8_fwd_tag",   256'(ot8), 256'(4'ha));
    v8 = 1'b1; m8 = 1'b1; t8 = 4'hb;
    step();
    v8 = 1'b0;
    chk("nb8_inv_col0", 256'(os8[0:31]), 256'(32'h001d1613));
    chk("nb8_inv_mode", 256'(om8), 256'(1'b1));

    // NB=8 inverse round trip on random data.
    for (int rep_i = 0; rep_i < 2; rep_i++) begin
      for (int j = 0; j < 8; j++) rnd[32*j +: 32] = $urandom();
      v8 = 1'b1; m8 = 1'b0; t8 = 4'h1; s8 = rnd;
      step();
      fw = os8;
      chk("nb8_rt_valid", 256'(ov8), 256'(1'b1));
      m8 = 1'b1; s8 = fw;
      step();
      v8 = 1'b0;
      chk("nb8_roundtrip", os8, rnd);
    end
    step();
    chk("nb8_drained", 256'(ov8), 256'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
